// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package mips_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } loader_state_e;

  // Bytes of length header in front of the payload.
  localparam int unsigned HeaderBytes = 2;

  // Instruction word width in bits.
  localparam int unsigned InstrWidth = 32;

  // True in the states that accept stream bytes.
  function automatic logic is_receive(loader_state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StCheck);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs big-endian bytes into instruction words and emits a one-cycle word_valid pulse.
module loader_word_assembler
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  last_byte,
  output logic                  word_valid,
  output logic [InstrWidth-1:0] word
);

  localparam int unsigned BytesPerWord = InstrWidth / 8;

  logic [1:0]            cnt_q;
  logic [InstrWidth-9:0] shift_q;
  logic                  word_valid_q;
  logic [InstrWidth-1:0] word_q;

  // The incoming byte completes a word when three bytes are already held.
  always_comb begin
    last_byte = (cnt_q == 2'(BytesPerWord - 1));
  end

  // Shift register, byte counter and the held output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (byte_valid) begin
        shift_q <= {shift_q[InstrWidth-17:0], byte_data};
        cnt_q   <= cnt_q + 2'd1;
        if (last_byte) begin
          word_valid_q <= 1'b1;
          word_q       <= {shift_q, byte_data};
        end
      end
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_program_loader.sv
// Receives a length-prefixed, XOR-checksummed program image over a byte stream and writes it
// into instruction memory, holding the core in reset until the image is verified.
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [InstrWidth-1:0] imem_wdata,
  output logic                  core_run,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned LenWidth = HeaderBytes * 8;
  localparam int unsigned MaxWords = 1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [7:0]            len_hi_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [7:0]            csum_q;
  logic [31:0]           tmo_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  accept;
  logic                  start_ok;
  logic                  data_accept;
  logic                  last_byte;
  logic                  word_done;
  logic [LenWidth-1:0]   len_full;

  // Handshake and event decode.
  always_comb begin
    in_ready    = is_receive(state_q);
    accept      = in_valid && in_ready;
    start_ok    = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
    data_accept = accept && (state_q == StData);
    word_done   = data_accept && last_byte;
    len_full    = {len_hi_q, in_data};
  end

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (data_accept),
    .byte_data  (in_data),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // Next-state logic; the idle timeout overrides the per-state transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) begin
          if (32'(len_full) > MaxWords) state_d = StError;
          else if (len_full == '0)      state_d = StCheck;
          else                          state_d = StData;
        end
      end
      StData: begin
        if (word_done && ((words_q + 1'b1) == len_q)) state_d = StCheck;
      end
      StCheck: begin
        if (accept) state_d = (in_data == csum_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
    if (is_receive(state_q) && !accept && (TIMEOUT_CYCLES != 0) &&
        ((tmo_q + 32'd1) == TIMEOUT_CYCLES)) begin
      state_d = StError;
    end
  end

  // State, length, checksum, timeout and write-address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok || accept || !is_receive(state_q)) tmo_q <= '0;
      else                                            tmo_q <= tmo_q + 32'd1;
      if (start_ok) begin
        csum_q   <= '0;
        words_q  <= '0;
        len_hi_q <= '0;
        len_q    <= '0;
      end else begin
        if (accept && (state_q != StCheck)) csum_q <= csum_q ^ in_data;
        if (accept && (state_q == StLenHi)) len_hi_q <= in_data;
        if (accept && (state_q == StLenLo)) len_q <= len_full[ADDR_WIDTH:0];
        if (word_done) begin
          words_q <= words_q + 1'b1;
          addr_q  <= words_q[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  // Status outputs decode straight from the state so they track it exactly.
  always_comb begin
    core_run     = (state_q == StDone);
    done         = (state_q == StDone);
    error        = (state_q == StError);
    imem_addr    = addr_q;
    words_loaded = words_q;
  end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  logic [7:0] nom [11];
  logic [7:0] bad [7];

  imem_program_loader #(
    .ADDR_WIDTH     (8),
    .TIMEOUT_CYCLES (5)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%h", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write got addr=%0h data=%h exp addr=%0h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout byte=%h got no_ready exp ready", b);
    end
  endtask

  task automatic send_nom(input int first, input int count, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      send_byte(nom[i]);
      if (gaps) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic push_nom();
    exp_q.push_back('{addr: 8'd0, data: 32'h2009_0005});
    exp_q.push_back('{addr: 8'd1, data: 32'h200A_000A});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes got %0d exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, imem_we, core_run, done, error} !== 5'b0 || imem_addr !== 8'h0 ||
        imem_wdata !== 32'h0 || words_loaded !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b run=%b done=%b err=%b addr=%h wd=%h wl=%0d exp all 0",
               in_ready, imem_we, core_run, done, error, imem_addr, imem_wdata, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b exp 0", in_ready);
    end
  endtask

  task automatic test_nominal();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nominal_ready_after_start got %b exp 1", in_ready);
    end
    push_nom();
    send_nom(0, 10, 0);
    checks++;
    if (done !== 1'b0 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL nominal_early_done got done=%b run=%b exp 0 0", done, core_run);
    end
    send_nom(10, 1, 0);
    checks++;
    if (done !== 1'b1 || core_run !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd2) begin
      errors++;
      $display("FAIL nominal_done got done=%b run=%b err=%b wl=%0d exp 1 1 0 2",
               done, core_run, error, words_loaded);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL nominal_ready_in_done got %b exp 0", in_ready);
    end
    check_drained("nominal");
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    checks++;
    if (done !== 1'b0 || core_run !== 1'b0 || words_loaded !== 9'd0) begin
      errors++;
      $display("FAIL restart_clear got done=%b run=%b wl=%0d exp 0 0 0", done, core_run, words_loaded);
    end
    exp_q.push_back('{addr: 8'd0, data: 32'h2009_0005});
    for (int i = 0; i < 7; i++) send_byte(bad[i]);
    checks++;
    if (error !== 1'b1 || core_run !== 1'b0 || done !== 1'b0 || words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL bad_checksum got err=%b run=%b done=%b wl=%0d exp 1 0 0 1",
               error, core_run, done, words_loaded);
    end
    check_drained("bad_checksum");
  endtask

  task automatic test_oversize();
    pulse_start();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL oversize_error_cleared got %b exp 0", error);
    end
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || words_loaded !== 9'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL oversize got err=%b rdy=%b wl=%0d we=%b exp 1 0 0 0",
               error, in_ready, words_loaded, imem_we);
    end
    @(posedge clk);
    #1;
    check_drained("oversize");
  endtask

  task automatic test_timeout();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h20);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (error !== (i == 5)) begin
        errors++;
        $display("FAIL timeout_idle_%0d got err=%b exp %b", i, error, (i == 5));
      end
    end
    checks++;
    if (in_ready !== 1'b0 || words_loaded !== 9'd0 || core_run !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state got rdy=%b wl=%0d run=%b exp 0 0 0", in_ready, words_loaded, core_run);
    end
    @(posedge clk);
    #1;
    check_drained("timeout");
  endtask

  task automatic test_gaps();
    pulse_start();
    push_nom();
    send_nom(0, 10, 1);
    send_nom(10, 1, 0);
    checks++;
    if (done !== 1'b1 || core_run !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd2) begin
      errors++;
      $display("FAIL gaps_done got done=%b run=%b err=%b wl=%0d exp 1 1 0 2",
               done, core_run, error, words_loaded);
    end
    check_drained("gaps");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_nom(0, 6, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, imem_we, core_run, done, error} !== 5'b0 || imem_addr !== 8'h0 ||
        imem_wdata !== 32'h0 || words_loaded !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b we=%b run=%b done=%b err=%b addr=%h wd=%h wl=%0d exp all 0",
               in_ready, imem_we, core_run, done, error, imem_addr, imem_wdata, words_loaded);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_drained("mid_reset_no_write");
    pulse_start();
    push_nom();
    send_nom(0, 11, 0);
    checks++;
    if (done !== 1'b1 || core_run !== 1'b1 || words_loaded !== 9'd2) begin
      errors++;
      $display("FAIL mid_reset_reload got done=%b run=%b wl=%0d exp 1 1 2", done, core_run, words_loaded);
    end
    check_drained("mid_reset_reload");
  endtask

  initial begin
    nom = '{8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h0A, 8'h0E};
    bad = '{8'h00, 8'h01, 8'h20, 8'h09, 8'h00, 8'h05, 8'h2C};
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize();
    test_timeout();
    test_gaps();
    test_reset_mid_load();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
